// File: rtl/mem_access_ctrl.sv
// Load/store controller bridging a core request port to a word-wide handshaked bus.
// Optional MISALIGN_TRAP_EN: fault misaligned half/word accesses without touching the bus.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_se,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e          state_q, state_d;
  logic            we_q, se_q;
  logic [31:0]     addr_q, wdata_q;
  logic [1:0]      size_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            fault_q, fault_d;
  logic            latch;

  logic            misalign;
  logic            is_byte, is_half, timeout_hit;
  logic [4:0]      shamt;
  logic [31:0]     shifted, load_data, lanes;
  logic [3:0]      be;

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((req_size == 2'b10) && req_addr[0]) ||
                    (((req_size == 2'b11) || (req_size == 2'b00)) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign is_byte     = (size_q == 2'b01);
  assign is_half     = (size_q == 2'b10);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Half-word ignores addr[0] and word ignores addr[1:0] when not trapping.
  always_comb begin
    shamt = 5'd0;
    if (is_byte) begin
      shamt = {addr_q[1:0], 3'b000};
    end else if (is_half) begin
      shamt = {addr_q[1], 4'b0000};
    end
    shifted   = bus_rdata >> shamt;
    load_data = shifted;
    if (is_byte) begin
      load_data = {{24{se_q & shifted[7]}}, shifted[7:0]};
    end else if (is_half) begin
      load_data = {{16{se_q & shifted[15]}}, shifted[15:0]};
    end
  end

  always_comb begin
    be    = 4'b1111;
    lanes = wdata_q;
    if (we_q && is_byte) begin
      be    = 4'b0001 << addr_q[1:0];
      lanes = {4{wdata_q[7:0]}};
    end else if (we_q && is_half) begin
      be    = 4'b0011 << {addr_q[1], 1'b0};
      lanes = {2{wdata_q[15:0]}};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          latch   = 1'b1;
          cnt_d   = '0;
          rdata_d = '0;
          fault_d = misalign;
          state_d = misalign ? StResp : StBus;
        end
      end
      StBus: begin
        // Completion beats a timeout that expires on the same cycle.
        if (bus_ready) begin
          rdata_d = we_q ? 32'h0 : load_data;
          fault_d = 1'b0;
          state_d = StResp;
        end else if (timeout_hit) begin
          rdata_d = '0;
          fault_d = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      se_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      if (latch) begin
        we_q    <= req_we;
        se_q    <= req_se;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
      end
    end
  end

  always_comb begin
    req_ready  = (state_q == StIdle) && !rst;
    bus_valid  = (state_q == StBus) && !rst;
    bus_we     = bus_valid & we_q;
    bus_addr   = {addr_q[31:2], 2'b00};
    bus_be     = bus_valid ? be : 4'b0000;
    bus_wdata  = bus_valid ? lanes : 32'h0;
    resp_valid = (state_q == StResp) && !rst;
    resp_rdata = resp_valid ? rdata_q : 32'h0;
    resp_fault = resp_valid & fault_q;
  end

endmodule
